// File: rtl/player_kinematics.sv
// -----------------------------------------------------------------------------
// player_kinematics
//
// Player movement controller for a side-scrolling game. Tracks the player's
// pixel position, facing direction and motion state (idle / run / jump / fall)
// from level-sensitive key inputs and per-side collision flags.
//
// Motion on each axis is paced by an interval counter: a pixel step happens
// once the counter has run for "interval" consecutive cycles. The horizontal
// interval is fixed. The vertical interval grows during ascent (the player
// slows toward the apex) and shrinks during descent (the player accelerates
// up to a terminal rate).
//
// Ports
//   clk         in   clock, all state updates on the rising edge
//   rst         in   synchronous, active-high reset
//   keys[3:0]   in   {jump, fall, left, right}, level, already synchronised
//   is_collide  in   {up, down, left, right} blocked-this-cycle flags
//   direction   out  facing: 0 left, 1 right
//   action      out  00 idle, 01 run, 10 jump, 11 fall (this is the FSM state)
//   pos_x/pos_y out  player position in pixels (y grows downward)
//   jumps_used  out  jumps consumed since the last landing
// -----------------------------------------------------------------------------
module player_kinematics #(
    parameter int POS_W        = 10,
    parameter int INIT_X       = 200,
    parameter int INIT_Y       = 556,
    parameter int X_MAX        = 799,
    parameter int Y_MAX        = 599,
    parameter int X_INV        = 200,
    parameter int JUMP_INV     = 20,
    parameter int FALL_INV     = 105,
    parameter int FALL_INV_MIN = 20,
    parameter int MAX_JUMPS    = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       keys,
    input  logic [3:0]       is_collide,
    output logic             direction,
    output logic [1:0]       action,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output logic [2:0]       jumps_used
);

    // State encoding doubles as the action output.
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_JUMP = 2'b10;
    localparam logic [1:0] S_FALL = 2'b11;

    localparam logic [CNT_W-1:0] X_INTERVAL   = CNT_W'(X_INV);
    localparam logic [CNT_W-1:0] ASCENT_START = CNT_W'(JUMP_INV);
    localparam logic [CNT_W-1:0] DESCENT_INIT = CNT_W'(FALL_INV);
    localparam logic [CNT_W-1:0] DESCENT_MIN  = CNT_W'(FALL_INV_MIN);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [POS_W-1:0] POS_ONE      = POS_W'(1);
    localparam logic [POS_W-1:0] X_LIMIT      = POS_W'(X_MAX);
    localparam logic [POS_W-1:0] Y_LIMIT      = POS_W'(Y_MAX);

    // Named views of the input buses.
    logic key_jump, key_fall, key_left, key_right;
    logic col_up, col_down, col_left, col_right;

    assign key_jump  = keys[3];
    assign key_fall  = keys[2];
    assign key_left  = keys[1];
    assign key_right = keys[0];

    assign col_up    = is_collide[3];
    assign col_down  = is_collide[2];
    assign col_left  = is_collide[1];
    assign col_right = is_collide[0];

    // Registered state beyond the outputs.
    logic             jump_prev;
    logic [CNT_W-1:0] x_cnt;
    logic [CNT_W-1:0] y_cnt;
    logic [CNT_W-1:0] y_inv;

    // -------------------------------------------------------------------------
    // Shared decode
    // -------------------------------------------------------------------------
    logic       jump_edge;
    logic       can_jump;
    logic       grounded;
    logic       walk;
    logic [1:0] ground_state;

    assign jump_edge    = key_jump & ~jump_prev;
    assign can_jump     = jumps_used < 3'(MAX_JUMPS);
    assign grounded     = ~action[1];
    // Pressing both horizontal keys cancels out.
    assign walk         = key_left ^ key_right;
    assign ground_state = walk ? S_RUN : S_IDLE;

    // -------------------------------------------------------------------------
    // Horizontal pacing
    // -------------------------------------------------------------------------
    logic             x_blocked;
    logic             x_go;
    logic [CNT_W-1:0] x_cnt_inc;
    logic             x_tick;

    assign x_blocked = key_left ? col_left : col_right;
    assign x_go      = walk & ~x_blocked;
    assign x_cnt_inc = x_cnt + CNT_ONE;
    assign x_tick    = x_go && (x_cnt_inc == X_INTERVAL);

    // -------------------------------------------------------------------------
    // Vertical FSM
    //
    // Priority: in-air fall key, then a usable jump edge, then the per-state
    // behaviour. A fall key held while already falling simply keeps the
    // normal descent running so the player continues to accelerate.
    // -------------------------------------------------------------------------
    logic [1:0]       action_n;
    logic [2:0]       jumps_n;
    logic [CNT_W-1:0] y_cnt_n;
    logic [CNT_W-1:0] y_inv_n;
    logic             y_up;
    logic             y_down;
    logic             fall_step;
    logic [CNT_W-1:0] y_cnt_inc;
    logic             y_tick;
    logic [CNT_W-1:0] inv_up;

    assign y_cnt_inc = y_cnt + CNT_ONE;
    assign y_tick    = (y_cnt_inc == y_inv);
    assign inv_up    = y_inv + CNT_ONE;

    always_comb begin
        action_n  = action;
        jumps_n   = jumps_used;
        y_cnt_n   = y_cnt;
        y_inv_n   = y_inv;
        y_up      = 1'b0;
        y_down    = 1'b0;
        fall_step = 1'b0;

        if (!grounded && key_fall) begin
            if (action == S_JUMP) begin
                action_n = S_FALL;
                y_inv_n  = DESCENT_INIT;
                y_cnt_n  = '0;
            end else begin
                fall_step = 1'b1;
            end
        end else if (jump_edge && can_jump) begin
            // Also valid mid-air: restarts the ascent profile.
            action_n = S_JUMP;
            jumps_n  = jumps_used + 3'd1;
            y_inv_n  = ASCENT_START;
            y_cnt_n  = '0;
        end else if (grounded) begin
            y_cnt_n = '0;
            if (!col_down) begin
                // Walked off a ledge: start descending, keep the jump budget.
                action_n = S_FALL;
                y_inv_n  = DESCENT_INIT;
            end else begin
                action_n = ground_state;
                jumps_n  = 3'd0;
            end
        end else if (action == S_JUMP) begin
            if (col_up) begin
                // Head hit a ceiling: no upward pixel, start falling.
                action_n = S_FALL;
                y_inv_n  = DESCENT_INIT;
                y_cnt_n  = '0;
            end else if (y_tick) begin
                y_up    = 1'b1;
                y_cnt_n = '0;
                // Slow down each pixel; at the descent starting rate we are
                // at the apex.
                if (inv_up >= DESCENT_INIT) begin
                    action_n = S_FALL;
                    y_inv_n  = DESCENT_INIT;
                end else begin
                    y_inv_n = inv_up;
                end
            end else begin
                y_cnt_n = y_cnt_inc;
            end
        end else begin
            fall_step = 1'b1;
        end

        if (fall_step) begin
            if (col_down) begin
                action_n = ground_state;
                jumps_n  = 3'd0;
                y_cnt_n  = '0;
            end else if (y_tick) begin
                y_down  = 1'b1;
                y_cnt_n = '0;
                // Accelerate toward terminal velocity.
                if (y_inv > DESCENT_MIN)
                    y_inv_n = y_inv - CNT_ONE;
                else
                    y_inv_n = DESCENT_MIN;
            end else begin
                y_cnt_n = y_cnt_inc;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_x      <= POS_W'(INIT_X);
            pos_y      <= POS_W'(INIT_Y);
            direction  <= 1'b1;
            action     <= S_IDLE;
            jumps_used <= 3'd0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            y_inv      <= DESCENT_INIT;
            jump_prev  <= 1'b0;
        end else begin
            jump_prev <= key_jump;

            // Facing follows the requested direction even when blocked.
            if (walk)
                direction <= key_right;

            if (x_go) begin
                if (x_tick) begin
                    x_cnt <= '0;
                    // Moves past the edge are dropped, never wrapped.
                    if (key_right) begin
                        if (pos_x < X_LIMIT)
                            pos_x <= pos_x + POS_ONE;
                    end else if (pos_x != '0) begin
                        pos_x <= pos_x - POS_ONE;
                    end
                end else begin
                    x_cnt <= x_cnt_inc;
                end
            end else begin
                x_cnt <= '0;
            end

            action     <= action_n;
            jumps_used <= jumps_n;
            y_cnt      <= y_cnt_n;
            y_inv      <= y_inv_n;

            if (y_up && pos_y != '0)
                pos_y <= pos_y - POS_ONE;
            else if (y_down && pos_y < Y_LIMIT)
                pos_y <= pos_y + POS_ONE;
        end
    end

endmodule

// File: tb/tb_player_kinematics.sv
// -----------------------------------------------------------------------------
// tb_player_kinematics
//
// Bench for player_kinematics with short intervals so whole jump arcs fit in a
// few dozen cycles. A behavioural model tracks the player every cycle; a table
// of hand-computed checkpoints and a few directed sequences cover the
// walk/jump/fall/land arcs, saturation and reset; a randomized phase then
// exercises arbitrary key/collision mixes against the model.
// -----------------------------------------------------------------------------
module tb_player_kinematics;

    localparam int POS_W        = 10;
    localparam int INIT_X       = 200;
    localparam int INIT_Y       = 556;
    localparam int X_MAX        = 799;
    localparam int Y_MAX        = 599;
    localparam int X_INV        = 4;
    localparam int JUMP_INV     = 2;
    localparam int FALL_INV     = 5;
    localparam int FALL_INV_MIN = 2;
    localparam int MAX_JUMPS    = 2;
    localparam int CNT_W        = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       keys;
    logic [3:0]       is_collide;
    logic             direction;
    logic [1:0]       action;
    logic [POS_W-1:0] pos_x;
    logic [POS_W-1:0] pos_y;
    logic [2:0]       jumps_used;

    int errors = 0;
    int checks = 0;

    player_kinematics #(
        .POS_W(POS_W), .INIT_X(INIT_X), .INIT_Y(INIT_Y), .X_MAX(X_MAX),
        .Y_MAX(Y_MAX), .X_INV(X_INV), .JUMP_INV(JUMP_INV), .FALL_INV(FALL_INV),
        .FALL_INV_MIN(FALL_INV_MIN), .MAX_JUMPS(MAX_JUMPS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .keys(keys), .is_collide(is_collide),
        .direction(direction), .action(action), .pos_x(pos_x), .pos_y(pos_y),
        .jumps_used(jumps_used)
    );

    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Behavioural model: plain integers, rules taken straight from the
    // movement description (pacing as "cycles elapsed since last pixel").
    // -------------------------------------------------------------------------
    int m_x, m_y, m_dir, m_act, m_jumps, m_xwait, m_ywait, m_yint, m_prev;

    task automatic m_reset();
        m_x = INIT_X; m_y = INIT_Y; m_dir = 1; m_act = 0; m_jumps = 0;
        m_xwait = 0; m_ywait = 0; m_yint = FALL_INV; m_prev = 0;
    endtask

    task automatic m_step(input logic r, input logic [3:0] k, input logic [3:0] c);
        bit jmp, fal, lft, rgt, edge_seen, lr, air, descend;
        if (r) begin
            m_reset();
            return;
        end
        jmp = k[3]; fal = k[2]; lft = k[1]; rgt = k[0];
        edge_seen = jmp && (m_prev == 0);
        m_prev = jmp;
        lr = (lft != rgt);
        air = (m_act >= 2);
        descend = 0;

        // Horizontal: one pixel per X_INV unblocked cycles of a single key.
        if (lr) begin
            m_dir = rgt;
            if ((lft && c[1]) || (rgt && c[0])) m_xwait = 0;
            else begin
                m_xwait++;
                if (m_xwait == X_INV) begin
                    m_xwait = 0;
                    if (rgt) m_x = (m_x < X_MAX) ? m_x + 1 : m_x;
                    else     m_x = (m_x > 0) ? m_x - 1 : m_x;
                end
            end
        end else m_xwait = 0;

        // Vertical.
        if (air && fal) begin
            if (m_act == 2) begin m_act = 3; m_yint = FALL_INV; m_ywait = 0; end
            else descend = 1;
        end else if (edge_seen && m_jumps < MAX_JUMPS) begin
            m_act = 2; m_jumps++; m_yint = JUMP_INV; m_ywait = 0;
        end else if (!air) begin
            m_ywait = 0;
            if (!c[2]) begin m_act = 3; m_yint = FALL_INV; end
            else begin m_act = lr ? 1 : 0; m_jumps = 0; end
        end else if (m_act == 2) begin
            if (c[3]) begin m_act = 3; m_yint = FALL_INV; m_ywait = 0; end
            else begin
                m_ywait++;
                if (m_ywait == m_yint) begin
                    m_ywait = 0;
                    if (m_y > 0) m_y--;
                    m_yint++;
                    if (m_yint >= FALL_INV) begin m_act = 3; m_yint = FALL_INV; end
                end
            end
        end else descend = 1;

        if (descend) begin
            if (c[2]) begin m_act = lr ? 1 : 0; m_jumps = 0; m_ywait = 0; end
            else begin
                m_ywait++;
                if (m_ywait == m_yint) begin
                    m_ywait = 0;
                    if (m_y < Y_MAX) m_y++;
                    m_yint = (m_yint - 1 < FALL_INV_MIN) ? FALL_INV_MIN : m_yint - 1;
                end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // Checking helpers
    // -------------------------------------------------------------------------
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    function automatic logic [25:0] dut_state();
        return {direction, action, pos_x, pos_y, jumps_used};
    endfunction

    function automatic logic [25:0] model_state();
        return {1'(m_dir), 2'(m_act), 10'(m_x), 10'(m_y), 3'(m_jumps)};
    endfunction

    // One clock: drive, let the edge happen, advance model, compare just after.
    task automatic cyc(input logic r, input logic [3:0] k, input logic [3:0] c);
        rst = r; keys = k; is_collide = c;
        @(posedge clk);
        m_step(r, k, c);
        #1;
        chk("model {dir,act,x,y,jumps}", 64'(dut_state()), 64'(model_state()));
    endtask

    // -------------------------------------------------------------------------
    // Checkpoint table: apply inputs for n cycles, then expect the outputs.
    // -------------------------------------------------------------------------
    typedef struct {
        logic [3:0] k;
        logic [3:0] c;
        int n;
        int act;
        int x;
        int y;
        int jmp;
        int dir;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic [3:0] k, input logic [3:0] c, input int n,
                               input int act, input int x, input int y,
                               input int jmp, input int dir);
        vec_t t;
        t.k = k; t.c = c; t.n = n; t.act = act; t.x = x; t.y = y; t.jmp = jmp; t.dir = dir;
        return t;
    endfunction

    initial begin
        int guard;
        logic [25:0] exp_s;

        // keys = {jump, fall, left, right}; is_collide = {up, down, left, right}
        // Walk right, then blocked on the right, then stop.
        tbl.push_back(v(4'b0001, 4'b0100, 12, 1, 203, 556, 0, 1));
        tbl.push_back(v(4'b0001, 4'b0101,  8, 1, 203, 556, 0, 1));
        tbl.push_back(v(4'b0000, 4'b0100,  2, 0, 203, 556, 0, 1));
        // Single jump: ascent pixels after 2,3,4 cycles, then fall.
        tbl.push_back(v(4'b1000, 4'b0100,  1, 2, 203, 556, 1, 1));
        tbl.push_back(v(4'b0000, 4'b0000,  9, 3, 203, 553, 1, 1));
        // Descent pixel gaps 5,4,3,2,2.
        tbl.push_back(v(4'b0000, 4'b0000,  4, 3, 203, 553, 1, 1));
        tbl.push_back(v(4'b0000, 4'b0000,  1, 3, 203, 554, 1, 1));
        tbl.push_back(v(4'b0000, 4'b0000,  3, 3, 203, 554, 1, 1));
        tbl.push_back(v(4'b0000, 4'b0000,  1, 3, 203, 555, 1, 1));
        tbl.push_back(v(4'b0000, 4'b0000,  2, 3, 203, 555, 1, 1));
        tbl.push_back(v(4'b0000, 4'b0000,  1, 3, 203, 556, 1, 1));
        tbl.push_back(v(4'b0000, 4'b0000,  1, 3, 203, 556, 1, 1));
        tbl.push_back(v(4'b0000, 4'b0000,  1, 3, 203, 557, 1, 1));
        tbl.push_back(v(4'b0000, 4'b0000,  1, 3, 203, 557, 1, 1));
        tbl.push_back(v(4'b0000, 4'b0000,  1, 3, 203, 558, 1, 1));
        // Land.
        tbl.push_back(v(4'b0000, 4'b0100,  1, 0, 203, 558, 0, 1));
        // Three jump edges in the air: third is ignored.
        tbl.push_back(v(4'b1000, 4'b0100,  1, 2, 203, 558, 1, 1));
        tbl.push_back(v(4'b0000, 4'b0000,  1, 2, 203, 558, 1, 1));
        tbl.push_back(v(4'b1000, 4'b0000,  1, 2, 203, 558, 2, 1));
        tbl.push_back(v(4'b0000, 4'b0000,  1, 2, 203, 558, 2, 1));
        tbl.push_back(v(4'b1000, 4'b0000,  1, 2, 203, 557, 2, 1));
        // Jump held 50 cycles: no retrigger, arc finishes and falls.
        tbl.push_back(v(4'b1000, 4'b0000, 50, 3, 203, 573, 2, 1));
        tbl.push_back(v(4'b0000, 4'b0100,  1, 0, 203, 573, 0, 1));
        // Ceiling hit during ascent.
        tbl.push_back(v(4'b1000, 4'b0100,  1, 2, 203, 573, 1, 1));
        tbl.push_back(v(4'b0000, 4'b1000,  1, 3, 203, 573, 1, 1));
        tbl.push_back(v(4'b0000, 4'b0100,  1, 0, 203, 573, 0, 1));
        // Fall key forces descent and beats a same-cycle jump edge.
        tbl.push_back(v(4'b1000, 4'b0100,  1, 2, 203, 573, 1, 1));
        tbl.push_back(v(4'b0100, 4'b0000,  1, 3, 203, 573, 1, 1));
        tbl.push_back(v(4'b1100, 4'b0000,  1, 3, 203, 573, 1, 1));
        tbl.push_back(v(4'b0000, 4'b0100,  1, 0, 203, 573, 0, 1));

        m_reset();
        cyc(1'b1, 4'b0000, 4'b0100);
        cyc(1'b1, 4'b0000, 4'b0100);
        chk("reset pos_x", 64'(pos_x), 64'(INIT_X));
        chk("reset pos_y", 64'(pos_y), 64'(INIT_Y));
        chk("reset action", 64'(action), 64'd0);
        chk("reset direction", 64'(direction), 64'd1);
        chk("reset jumps_used", 64'(jumps_used), 64'd0);

        foreach (tbl[i]) begin
            for (int j = 0; j < tbl[i].n; j++) cyc(1'b0, tbl[i].k, tbl[i].c);
            exp_s = {1'(tbl[i].dir), 2'(tbl[i].act), 10'(tbl[i].x), 10'(tbl[i].y), 3'(tbl[i].jmp)};
            chk($sformatf("vector %0d {dir,act,x,y,jumps}", i), 64'(dut_state()), 64'(exp_s));
        end

        // Left edge saturation: long left walk must stop at 0.
        for (int j = 0; j < 203 * X_INV + 20; j++) cyc(1'b0, 4'b0010, 4'b0100);
        chk("left saturate pos_x", 64'(pos_x), 64'd0);
        chk("left saturate direction", 64'(direction), 64'd0);
        chk("left saturate action", 64'(action), 64'd1);

        // Reset mid-fall at y=570 while walking right.
        cyc(1'b1, 4'b0000, 4'b0000);
        guard = 0;
        while (pos_y != 10'd570 && guard < 200) begin
            cyc(1'b0, 4'b0001, 4'b0000);
            guard++;
        end
        chk("reach y=570 within budget", 64'(guard < 200), 64'd1);
        chk("mid-fall action", 64'(action), 64'd3);
        cyc(1'b1, 4'b0001, 4'b0000);
        exp_s = {1'b1, 2'b00, 10'(INIT_X), 10'(INIT_Y), 3'd0};
        chk("reset mid-fall {dir,act,x,y,jumps}", 64'(dut_state()), 64'(exp_s));

        // Bottom edge saturation.
        for (int j = 0; j < 200; j++) cyc(1'b0, 4'b0000, 4'b0000);
        chk("bottom saturate pos_y", 64'(pos_y), 64'(Y_MAX));
        chk("bottom saturate action", 64'(action), 64'd3);

        // Randomized mix against the model.
        cyc(1'b1, 4'b0000, 4'b0100);
        for (int j = 0; j < 3000; j++) begin
            logic [3:0] rk, rc;
            logic rr;
            rr    = ($urandom_range(0, 399) == 0);
            rk[3] = ($urandom_range(0, 3) == 0);
            rk[2] = ($urandom_range(0, 9) == 0);
            rk[1] = ($urandom_range(0, 2) == 0);
            rk[0] = ($urandom_range(0, 2) == 0);
            rc[3] = ($urandom_range(0, 9) == 0);
            rc[2] = ($urandom_range(0, 1) == 0);
            rc[1] = ($urandom_range(0, 5) == 0);
            rc[0] = ($urandom_range(0, 5) == 0);
            cyc(rr, rk, rc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/player_kinematics.md
PLAYER_KINEMATICS -- requirements
Module: player_kinematics

Interface
REQ-001 SHALL have parameter POS_W, default 10, position width in pixels.
REQ-002 SHALL have parameter INIT_X, default 200, spawn x.
REQ-003 SHALL have parameter INIT_Y, default 556, spawn y.
REQ-004 SHALL have parameter X_MAX / Y_MAX, default 799 / 599, position saturation limits.
REQ-005 SHALL have parameter X_INV, default 200, cycles per horizontal pixel.
REQ-006 SHALL have parameter JUMP_INV, default 20, initial ascent interval in cycles.
REQ-007 SHALL have parameter FALL_INV, default 105, initial descent interval, also the ascent apex interval.
REQ-008 SHALL have parameter FALL_INV_MIN, default 20, terminal descent interval.
REQ-009 SHALL have parameter MAX_JUMPS, default 2, jumps allowed before landing (1..7).
REQ-010 SHALL have parameter CNT_W, default 16, interval counter width.
REQ-011 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-012 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-013 SHALL have port keys  input  4  {jump, fall, left, right}, level, already synchronised.
REQ-014 SHALL have port is_collide  input  4  {up, down, left, right} blocked-this-cycle flags.
REQ-015 SHALL have port direction  output  1  facing, 0 left, 1 right.
REQ-016 SHALL have port action  output  2  00 idle, 01 run, 10 jump, 11 fall.
REQ-017 SHALL have port pos_x, pos_y  output  POS_W  player position.
REQ-018 SHALL have port jumps_used  output  3  jumps consumed since last landing.

Function
REQ-019 SHALL use a single always-on rising-edge domain; no negedge logic.
REQ-020 SHALL implement FSM IDLE/RUN/JUMP/FALL, encoded directly as action.
REQ-021 Grounded (IDLE/RUN) SHALL go RUN when left XOR right, else IDLE; jumps_used=0.
REQ-022 Grounded with is_collide[down]=0 SHALL go FALL, jumps_used unchanged, descent interval=FALL_INV.
REQ-023 A jump SHALL trigger only on the rising edge of keys[jump] (registered previous value), never on hold.
REQ-024 Jump edge with jumps_used<MAX_JUMPS, from any state, SHALL enter JUMP, increment jumps_used, ascent interval=JUMP_INV, clear vertical counter.
REQ-025 Jump edge with jumps_used==MAX_JUMPS SHALL be ignored.
REQ-026 In air, keys[fall]=1 SHALL force FALL (interval=FALL_INV) and override a same-cycle jump edge; grounded, keys[fall] ignored.
REQ-027 Each axis SHALL have a CNT_W counter incrementing while its move is requested and that side unblocked; when count+1==interval, move 1 pixel and clear; blocked or not requested clears it.
REQ-028 Horizontal: left-only moves -x, direction=0; right-only moves +x, direction=1; both or none no move, direction held.
REQ-029 JUMP: each up-pixel decrements pos_y then increments ascent interval; when it reaches FALL_INV go FALL, interval=FALL_INV.
REQ-030 JUMP with is_collide[up]=1 SHALL go FALL next cycle with no upward pixel that cycle.
REQ-031 FALL: each down-pixel increments pos_y then decrements interval, floored at FALL_INV_MIN.
REQ-032 FALL with is_collide[down]=1 SHALL land: IDLE/RUN per REQ-021, jumps_used=0, counter cleared.
REQ-033 pos_x SHALL saturate at 0 and X_MAX, pos_y at 0 and Y_MAX; saturated moves are dropped without wrap.
REQ-034 Horizontal and vertical motion SHALL be independent and may move in the same cycle.

Reset
REQ-035 rst SHALL set pos_x=INIT_X, pos_y=INIT_Y, direction=1, action=00, jumps_used=0, all counters 0, intervals to defaults, previous-jump register 0.
REQ-036 rst SHALL take priority over all inputs, including mid-jump and mid-fall.

Verification (X_INV=4, JUMP_INV=2, FALL_INV=5, FALL_INV_MIN=2, MAX_JUMPS=2)
REQ-037 Grounded, right held 12 cycles -> pos_x=INIT_X+3, action=01, direction=1; then is_collide[right]=1 -> pos_x frozen.
REQ-038 Grounded, one jump edge, no collisions -> pos_y falls by 3 over 9 cycles (intervals 2,3,4), then action=11.
REQ-039 In FALL, unblocked -> down-pixel gaps 5,4,3,2,2 cycles; is_collide[down]=1 -> action=00, jumps_used=0.
REQ-040 Three jump edges in air without landing -> jumps_used=2, third ignored; jump held 50 cycles -> no retrigger.
REQ-041 In JUMP, assert is_collide[up] -> action=11 next cycle, pos_y unchanged that cycle.
REQ-042 rst asserted mid-fall at pos_y=570 -> next cycle pos_y=556, pos_x=200, action=00, direction=1.
